// File: rtl/apu_pkg.sv
// Shared APU definitions: frame-sequencer step masks, indexed by the current step.
package apu_pkg;

  localparam logic [7:0] LEN_STEPS   = 8'b0101_0101;
  localparam logic [7:0] SWEEP_STEPS = 8'b0100_0100;
  localparam logic [7:0] ENV_STEPS   = 8'b1000_0000;

endpackage

// File: rtl/apu_div_edge.sv
// Selects the watched DIV bit for the current CPU speed and flags its falling edge.
module apu_div_edge #(
  parameter int SEL_NORMAL = 4,
  parameter int SEL_DOUBLE = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] div,
  input  logic       double_speed,
  output logic       sel,
  output logic       fall
);

  logic div_bit_q;

  // A mux switch can create an edge on its own; that is treated as a real event.
  assign sel  = double_speed ? div[SEL_DOUBLE] : div[SEL_NORMAL];
  assign fall = div_bit_q & ~sel;

  always_ff @(posedge clk) begin
    if (reset) div_bit_q <= 1'b0;
    else       div_bit_q <= sel;
  end

endmodule

// File: rtl/apu_frame_sequencer.sv
// DIV-APU frame sequencer: turns DIV falling edges into length, sweep and envelope clock pulses.
module apu_frame_sequencer
  import apu_pkg::*;
#(
  parameter int SEL_NORMAL = 4,
  parameter int SEL_DOUBLE = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] div,
  input  logic       double_speed,
  input  logic       apu_power,
  output logic       clk256_en,
  output logic       clk128_en,
  output logic       clk64_en,
  output logic [2:0] step,
  output logic       length_odd
);

  logic sel;
  logic fall;
  logic power_q;
  logic skip_first;

  apu_div_edge #(
    .SEL_NORMAL (SEL_NORMAL),
    .SEL_DOUBLE (SEL_DOUBLE)
  ) u_div_edge (
    .clk          (clk),
    .reset        (reset),
    .div          (div),
    .double_speed (double_speed),
    .sel          (sel),
    .fall         (fall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      power_q    <= 1'b0;
      skip_first <= 1'b0;
      step       <= 3'd0;
      clk256_en  <= 1'b0;
      clk128_en  <= 1'b0;
      clk64_en   <= 1'b0;
    end else begin
      power_q   <= apu_power;
      clk256_en <= 1'b0;
      clk128_en <= 1'b0;
      clk64_en  <= 1'b0;
      if (!apu_power) begin
        step       <= 3'd0;
        skip_first <= 1'b0;
      end else if (!power_q) begin
        // Watched bit already high at power-on: its coming fall is swallowed.
        skip_first <= sel;
      end else if (fall) begin
        if (skip_first) begin
          skip_first <= 1'b0;
        end else begin
          clk256_en <= LEN_STEPS[step];
          clk128_en <= SWEEP_STEPS[step];
          clk64_en  <= ENV_STEPS[step];
          step      <= step + 3'd1;
        end
      end
    end
  end

  assign length_odd = step[0];

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Scoreboard bench for apu_frame_sequencer: directed scenarios plus randomized DIV/power/reset traffic.
module tb_apu_frame_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] div;
  logic       double_speed;
  logic       apu_power;
  logic       clk256_en, clk128_en, clk64_en;
  logic [2:0] step;
  logic       length_odd;

  apu_frame_sequencer #(.SEL_NORMAL(4), .SEL_DOUBLE(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .div          (div),
    .double_speed (double_speed),
    .apu_power    (apu_power),
    .clk256_en    (clk256_en),
    .clk128_en    (clk128_en),
    .clk64_en     (clk64_en),
    .step         (step),
    .length_odd   (length_odd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       l;
    logic       s;
    logic       e;
    logic [2:0] st;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  n256 = 0, n128 = 0, n64 = 0;

  // Reference model state
  int  m_step = 0;
  bit  m_skip = 0, m_psel = 0, m_ppow = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied, then clock the DUT.
  task automatic cyc();
    bit  sel;
    bit  fall;
    ev_t ev;
    sel = double_speed ? div[5] : div[4];
    if (reset) begin
      m_step = 0; m_skip = 0; m_psel = 0; m_ppow = 0;
    end else begin
      fall = m_psel && !sel;
      if (!apu_power) begin
        m_step = 0;
        m_skip = 0;
      end else if (!m_ppow) begin
        m_skip = sel;
      end else if (fall) begin
        if (m_skip) begin
          m_skip = 0;
        end else begin
          ev.l  = (m_step % 2 == 0);
          ev.s  = (m_step % 4 == 2);
          ev.e  = (m_step == 7);
          m_step = (m_step + 1) % 8;
          ev.st = 3'(m_step);
          if (ev.l || ev.s || ev.e) exp_q.push_back(ev);
        end
      end
      m_psel = sel;
      m_ppow = apu_power;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".step"}, step, m_step);
    chk({tag, ".length_odd"}, length_odd, m_step % 2);
  endtask

  task automatic fall_bit(input int b);
    div[b] = 1'b1; cyc();
    div[b] = 1'b0; cyc();
  endtask

  // Monitor: every visible pulse must match the oldest predicted event.
  ev_t got_ev;
  always @(negedge clk) begin
    if ((clk256_en | clk128_en | clk64_en) === 1'b1) begin
      if (clk256_en === 1'b1) n256++;
      if (clk128_en === 1'b1) n128++;
      if (clk64_en === 1'b1) n64++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got len=%0b sweep=%0b env=%0b step=%0d expected no pulse (t=%0t)",
                 clk256_en, clk128_en, clk64_en, step, $time);
      end else begin
        got_ev = exp_q.pop_front();
        chk("pulse.len", clk256_en, got_ev.l);
        chk("pulse.sweep", clk128_en, got_ev.s);
        chk("pulse.env", clk64_en, got_ev.e);
        chk("pulse.step", step, got_ev.st);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; div = 8'h00; double_speed = 1'b0; apu_power = 1'b0;
    repeat (3) cyc();
    chk("reset.len", clk256_en, 0);
    chk("reset.sweep", clk128_en, 0);
    chk("reset.env", clk64_en, 0);
    check_state("reset");
    reset = 1'b0;
    cyc();

    // Power on with the watched bit low, then 16 falls of div[4].
    apu_power = 1'b1;
    cyc();
    n256 = 0; n128 = 0; n64 = 0;
    for (int i = 0; i < 16; i++) begin
      fall_bit(4);
      check_state("seq");
    end
    cyc();
    chk("count.len", n256, 8);
    chk("count.sweep", n128, 4);
    chk("count.env", n64, 2);

    // Power on with the watched bit high: first fall swallowed.
    apu_power = 1'b0; cyc(); cyc();
    div[4] = 1'b1; cyc();
    apu_power = 1'b1; cyc();
    div[4] = 1'b0; cyc(); cyc();
    check_state("skip.first");
    fall_bit(4);
    cyc();
    check_state("skip.second");

    // Advance to step 5, then power-off coincident with a fall.
    repeat (4) fall_bit(4);
    check_state("pre_off");
    div[4] = 1'b1; cyc();
    apu_power = 1'b0; div[4] = 1'b0; cyc(); cyc();
    check_state("off");
    repeat (3) fall_bit(4);
    check_state("off.falls");

    // Double speed: only div[5] matters.
    double_speed = 1'b1; apu_power = 1'b1; cyc();
    repeat (3) fall_bit(4);
    check_state("ds.bit4");
    repeat (3) fall_bit(5);
    check_state("ds.bit5");

    // Reach step 6, then reset with a fall pending.
    repeat (3) fall_bit(5);
    check_state("pre_reset");
    div[5] = 1'b1; cyc();
    reset = 1'b1; div[5] = 1'b0; cyc();
    reset = 1'b0;
    chk("rst.len", clk256_en, 0);
    check_state("rst");
    cyc();
    chk("rst.next_len", clk256_en, 0);

    // DIV reset write from 0x10 to 0x00 counts as an event.
    double_speed = 1'b0;
    div = 8'h10; cyc();
    div = 8'h00; cyc(); cyc();
    check_state("divwrite");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      div = 8'($urandom);
      if ($urandom_range(15) == 0) double_speed = ~double_speed;
      if ($urandom_range(31) == 0) apu_power = ~apu_power;
      reset = ($urandom_range(63) == 0);
      cyc();
      check_state("rand");
    end
    reset = 1'b0;
    repeat (3) cyc();
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
